// File: rtl/button_frontend.sv
// Pushbutton front-end: sync, debounce and press detect for two keys,
// display-mode register and decrement strobe with auto-repeat.

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module button_frontend #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       dec_btn,
    output logic [1:0] mode,
    output logic [7:0] mode_seg,
    output logic       mode_change,
    output logic       dec_pulse
);
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW = $clog2(RMAX);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } dec_state_t;

    logic btn_level;
    logic btn_level_d;
    logic dec_level;
    logic dec_level_d;
    logic btn_press;
    logic dec_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk  (clk),
        .reset(reset),
        .raw  (btn),
        .level(btn_level)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
        .clk  (clk),
        .reset(reset),
        .raw  (dec_btn),
        .level(dec_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_level_d <= 1'b1;
            dec_level_d <= 1'b1;
        end else begin
            btn_level_d <= btn_level;
            dec_level_d <= dec_level;
        end
    end

    // Active-low keys: a press is the debounced 1->0 transition
    assign btn_press = btn_level_d & ~btn_level;
    assign dec_press = dec_level_d & ~dec_level;

    dec_state_t    state;
    dec_state_t    state_nx;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nx;
    logic          req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        req      = 1'b0;
        unique case (state)
            IDLE: begin
                rcnt_nx = '0;
                if (dec_press) begin
                    req      = 1'b1;
                    state_nx = HELD;
                end
            end
            HELD: begin
                if (dec_level) begin
                    rcnt_nx  = '0;
                    state_nx = IDLE;
                end else if (rcnt == HOLD_LAST) begin
                    req      = 1'b1;
                    rcnt_nx  = '0;
                    state_nx = REPEAT;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (dec_level) begin
                    rcnt_nx  = '0;
                    state_nx = IDLE;
                end else if (rcnt == REP_LAST) begin
                    req     = 1'b1;
                    rcnt_nx = '0;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                end
            end
            default: begin
                rcnt_nx  = '0;
                state_nx = IDLE;
            end
        endcase
    end

    function automatic logic [7:0] seg_of(input logic [1:0] m);
        logic [7:0] s;
        case (m)
            2'd1:    s = 8'b00010001;
            2'd2:    s = 8'b01001001;
            default: s = 8'b10000101;
        endcase
        return s;
    endfunction

    logic [1:0] mode_nx;

    always_comb begin
        mode_nx = mode;
        if (btn_press) begin
            mode_nx = (mode == 2'd2) ? 2'd0 : mode + 2'd1;
        end
    end

    // dec_pulse gates on the mode held before this edge's update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode        <= 2'd0;
            mode_seg    <= 8'b10000101;
            mode_change <= 1'b0;
            dec_pulse   <= 1'b0;
        end else begin
            mode        <= mode_nx;
            mode_seg    <= seg_of(mode_nx);
            mode_change <= btn_press;
            dec_pulse   <= req & (mode == 2'd2);
        end
    end
endmodule

// File: tb/tb_button_frontend.sv
// Bench for button_frontend: press table, bounce, auto-repeat,
// mode gating, simultaneous presses and reset mid-repeat.

module tb_button_frontend;
    localparam logic [7:0] SEG0 = 8'b10000101;
    localparam logic [7:0] SEG1 = 8'b00010001;
    localparam logic [7:0] SEG2 = 8'b01001001;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic       dec_btn;
    logic [1:0] mode;
    logic [7:0] mode_seg;
    logic       mode_change;
    logic       dec_pulse;

    button_frontend #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .dec_btn    (dec_btn),
        .mode       (mode),
        .mode_seg   (mode_seg),
        .mode_change(mode_change),
        .dec_pulse  (dec_pulse)
    );

    always #5 clk = ~clk;

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int         cyc;
        logic       mc;
        logic       dp;
        logic [1:0] mode;
        logic [7:0] seg;
    } ev_t;

    typedef struct {
        int         low;
        int         high;
        logic [1:0] mode;
        logic [7:0] seg;
    } press_t;

    ev_t    q[$];
    press_t presses[3];
    int     checks   = 0;
    int     failures = 0;
    int     s;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic mc, input logic dp,
                        input logic [1:0] m, input logic [7:0] sg);
        ev_t e;
        e.cyc  = c;
        e.mc   = mc;
        e.dp   = dp;
        e.mode = m;
        e.seg  = sg;
        q.push_back(e);
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (mode_change === 1'b1 || dec_pulse === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: cyc=%0d mc=%b dp=%b",
                             ecount, mode_change, dec_pulse);
                end else begin
                    e = q.pop_front();
                    if (ecount != e.cyc || mode_change !== e.mc ||
                        dec_pulse !== e.dp || mode !== e.mode ||
                        mode_seg !== e.seg) begin
                        failures++;
                        $display("FAIL strobe: got cyc=%0d mc=%b dp=%b m=%0d seg=%b expected cyc=%0d mc=%b dp=%b m=%0d seg=%b",
                                 ecount, mode_change, dec_pulse, mode,
                                 mode_seg, e.cyc, e.mc, e.dp, e.mode, e.seg);
                    end
                end
            end
        end
    endtask

    task automatic drained(input string name);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected strobes missing, first at cyc=%0d",
                     name, q.size(), q[0].cyc);
        end
        q.delete();
    endtask

    task automatic press_btn(input int low, input int high,
                             input logic [1:0] m, input logic [7:0] sg);
        push(ecount + 7, 1'b1, 1'b0, m, sg);
        btn = 1'b0;
        tick(low);
        btn = 1'b1;
        tick(high);
        check("press_mode", 32'(mode), 32'(m));
        check("press_seg", 32'(mode_seg), 32'(sg));
    endtask

    initial begin
        presses[0] = '{low: 10, high: 12, mode: 2'd1, seg: SEG1};
        presses[1] = '{low: 10, high: 12, mode: 2'd2, seg: SEG2};
        presses[2] = '{low: 10, high: 12, mode: 2'd0, seg: SEG0};

        reset   = 1'b0;
        btn     = 1'b1;
        dec_btn = 1'b1;
        fork
            monitor();
        join_none
        tick(3);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_seg", 32'(mode_seg), 32'(SEG0));
        check("rst_mc", 32'(mode_change), 32'd0);
        check("rst_dp", 32'(dec_pulse), 32'd0);
        reset = 1'b1;
        tick(3);

        for (int i = 0; i < 3; i++) begin
            press_btn(presses[i].low, presses[i].high,
                      presses[i].mode, presses[i].seg);
        end
        drained("press_table");

        for (int i = 0; i < 5; i++) begin
            btn = 1'b0;
            tick(3);
            btn = 1'b1;
            tick(2);
        end
        press_btn(10, 12, 2'd1, SEG1);
        drained("bounce");

        press_btn(10, 12, 2'd2, SEG2);
        s = ecount;
        push(s + 7, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 27, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 35, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 43, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 51, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 59, 1'b0, 1'b1, 2'd2, SEG2);
        dec_btn = 1'b0;
        tick(56);
        dec_btn = 1'b1;
        tick(30);
        drained("auto_repeat");

        press_btn(10, 12, 2'd0, SEG0);
        dec_btn = 1'b0;
        tick(40);
        dec_btn = 1'b1;
        tick(20);
        drained("mode0_suppress");

        press_btn(10, 12, 2'd1, SEG1);
        press_btn(10, 12, 2'd2, SEG2);
        s = ecount;
        push(s + 7, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 27, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 35, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 37, 1'b1, 1'b0, 2'd0, SEG0);
        dec_btn = 1'b0;
        tick(30);
        btn = 1'b0;
        tick(10);
        btn = 1'b1;
        tick(20);
        dec_btn = 1'b1;
        tick(20);
        drained("mode_exit_stops");

        press_btn(10, 12, 2'd1, SEG1);
        press_btn(10, 12, 2'd2, SEG2);
        s = ecount;
        push(s + 7, 1'b1, 1'b1, 2'd0, SEG0);
        btn     = 1'b0;
        dec_btn = 1'b0;
        tick(10);
        btn     = 1'b1;
        dec_btn = 1'b1;
        tick(20);
        check("simul_mode", 32'(mode), 32'd0);
        drained("simultaneous");

        press_btn(10, 12, 2'd1, SEG1);
        press_btn(10, 12, 2'd2, SEG2);
        s = ecount;
        push(s + 7, 1'b0, 1'b1, 2'd2, SEG2);
        push(s + 27, 1'b0, 1'b1, 2'd2, SEG2);
        dec_btn = 1'b0;
        tick(35);
        check("repeat_pulse_live", 32'(dec_pulse), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_dp", 32'(dec_pulse), 32'd0);
        check("async_rst_mode", 32'(mode), 32'd0);
        check("async_rst_seg", 32'(mode_seg), 32'(SEG0));
        check("async_rst_mc", 32'(mode_change), 32'd0);
        dec_btn = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(40);
        check("post_rst_mode", 32'(mode), 32'd0);
        drained("reset_in_repeat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
